program_run_ctrl: RTL and testbench

//   Parametrised run sequencer for the 9-bit RISC core. Replaces the single

---
 rtl/program_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_program_run_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_run_ctrl.sv
// Run sequencer for the 9-bit RISC core: start/init/run/done FSM, per-program halt PC, RUN cycle counter.
// Optional watchdog enabled by defining PRG_WATCHDOG_EN; default build has timeout tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a start edge after reset
// INIT    | init held high for INIT_CYC cycles, pc ignored
// RUN     | core executing, cycles counted, halt PC compared each cycle
// DONE    | program halted, done high, cycle_cnt frozen until next launch
module program_run_ctrl #(
    parameter int PC_W = 12,
    parameter int NUM_PROGS = 3,
    parameter int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    parameter logic [NUM_PROGS*PC_W-1:0] HALT_ADDR = {12'd139, 12'd90, 12'd71},
    parameter int INIT_CYC = 2,
`ifdef PRG_WATCHDOG_EN
    parameter int WD_LIMIT = 4096,
`endif
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] prog_sel,
    input  logic [PC_W-1:0]  pc,
    output logic             init,
    output logic             busy,
    output logic             done,
    output logic             sel_err,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [ICW-1:0] INIT_LOAD = ICW'(INIT_CYC - 1);
    localparam logic [SEL_W:0] NUM_PROGS_W = (SEL_W + 1)'(NUM_PROGS);

    logic [1:0]       state_q, state_d;
    logic             start_q;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [ICW-1:0]   init_cnt_q, init_cnt_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             sel_err_q, sel_err_d;
    logic             start_edge;
    logic             sel_ok;
    logic             halt_hit;
    logic [PC_W-1:0]  halt_pc;

`ifdef PRG_WATCHDOG_EN
    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_LOAD = WDW'(WD_LIMIT - 1);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    // Entry i is the i-th field of HALT_ADDR reading left to right, so the
    // default table gives program 0 -> 139, program 1 -> 90, program 2 -> 71.
    always_comb begin
        halt_pc = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                halt_pc = HALT_ADDR[(NUM_PROGS-1-i)*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        start_edge  = start & ~start_q;
        sel_ok      = ({1'b0, prog_sel} < NUM_PROGS_W);
        halt_hit    = (pc == halt_pc);
        state_d     = state_q;
        sel_d       = sel_q;
        init_cnt_d  = init_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        sel_err_d   = 1'b0;
`ifdef PRG_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    if (sel_ok) begin
                        state_d     = ST_INIT;
                        sel_d       = prog_sel;
                        init_cnt_d  = INIT_LOAD;
                        cycle_cnt_d = '0;
`ifdef PRG_WATCHDOG_EN
                        wd_cnt_d    = WD_LOAD;
                        timeout_d   = 1'b0;
`endif
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
                // Halt match takes priority over a watchdog expiring on the same cycle.
                if (halt_hit) begin
                    state_d = ST_DONE;
`ifdef PRG_WATCHDOG_EN
                end else if (wd_cnt_q == '0) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q - 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            sel_q       <= '0;
            init_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            sel_err_q   <= 1'b0;
`ifdef PRG_WATCHDOG_EN
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            sel_q       <= sel_d;
            init_cnt_q  <= init_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            sel_err_q   <= sel_err_d;
`ifdef PRG_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign init      = (state_q == ST_INIT);
    assign busy      = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sel_err   = sel_err_q;
    assign cycle_cnt = cycle_cnt_q;
`ifdef PRG_WATCHDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_program_run_ctrl.sv
// Directed bench for program_run_ctrl: a 32-bit counter instance and a 4-bit (saturating) instance share stimulus.
// Expected cycle counts are queued at launch and popped when done is observed.
module tb_program_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic [11:0] pc;
    logic        init, busy, done, sel_err, timeout;
    logic [31:0] cycle_cnt;
    logic        s_init, s_busy, s_done, s_sel_err, s_timeout;
    logic [3:0]  s_cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_sat_q[$];

    always #5 clk = ~clk;

    program_run_ctrl #(
        .CYC_W(32)
`ifdef PRG_WATCHDOG_EN
        , .WD_LIMIT(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .pc(pc),
        .init(init), .busy(busy), .done(done), .sel_err(sel_err),
        .cycle_cnt(cycle_cnt), .timeout(timeout)
    );

    program_run_ctrl #(
        .CYC_W(4)
`ifdef PRG_WATCHDOG_EN
        , .WD_LIMIT(16)
`endif
    ) dut_sat (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .pc(pc),
        .init(s_init), .busy(s_busy), .done(s_done), .sel_err(s_sel_err),
        .cycle_cnt(s_cycle_cnt), .timeout(s_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input int n);
        exp_q.push_back(n);
        exp_sat_q.push_back((n > 15) ? 15 : n);
    endtask

    // Start pulse, then walk through the two INIT cycles with pc parked on the
    // halt address to show INIT ignores it.
    task automatic launch(input logic [1:0] sel, input logic [11:0] halt);
        prog_sel = sel;
        pc       = halt;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_init", init, 1);
        chk("launch_busy", busy, 1);
        chk("launch_done_clr", done, 0);
        chk("launch_cnt_clr", cycle_cnt, 0);
        tick();
        chk("init_2nd_cycle", init, 1);
        tick();
        chk("init_dropped", init, 0);
        chk("run_busy", busy, 1);
    endtask

    task automatic run_cycles(input int n, input logic [11:0] last_pc, input logic [11:0] decoy);
        for (int i = 1; i <= n; i++) begin
            pc = (i == n) ? last_pc : decoy;
            tick();
        end
        pc = 12'd0;
    endtask

    task automatic check_done(input logic exp_to);
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_init", init, 0);
        chk("done_timeout", timeout, exp_to);
        chk("sat_done", s_done, 1);
        chk("sat_timeout", s_timeout, exp_to);
        if (exp_q.size() > 0 && exp_sat_q.size() > 0) begin
            chk("cycle_cnt", cycle_cnt, exp_q.pop_front());
            chk("sat_cycle_cnt", s_cycle_cnt, exp_sat_q.pop_front());
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        prog_sel = 2'd0;
        pc       = 12'd0;
        tick();
        tick();
        chk("rst_init", init, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b1;
        tick();

        // Bad program index from IDLE
        prog_sel = 2'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_sel_err", sel_err, 1);
        chk("idle_sat_sel_err", s_sel_err, 1);
        chk("idle_sel_err_busy", busy, 0);
        chk("idle_sel_err_init", init, 0);
        tick();
        chk("idle_sel_err_pulse", sel_err, 0);
        chk("idle_stays", busy, 0);

        // Program 2 halts at 71 on its 40th RUN cycle
        launch(2'd2, 12'd71);
        expect_done(40);
        run_cycles(40, 12'd71, 12'd139);
        check_done(1'b0);

        // Program 0 halts at 139; 71 on the way must not stop it
        launch(2'd0, 12'd139);
        expect_done(10);
        run_cycles(10, 12'd139, 12'd71);
        check_done(1'b0);

        // Program 1 halts on the very first RUN cycle
        launch(2'd1, 12'd90);
        expect_done(1);
        run_cycles(1, 12'd90, 12'd0);
        check_done(1'b0);

        // Bad program index from DONE retains done and count
        prog_sel = 2'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("done_sel_err", sel_err, 1);
        chk("done_sel_err_done", done, 1);
        chk("done_sel_err_cnt", cycle_cnt, 1);
        tick();
        chk("done_sel_err_pulse", sel_err, 0);
        chk("done_retained", done, 1);

        // Start held high for 100 cycles launches once
        prog_sel = 2'd1;
        pc       = 12'd0;
        start    = 1'b1;
        repeat (100) tick();
        chk("held_busy", busy, 1);
        chk("held_init", init, 0);
        chk("held_cnt", cycle_cnt, 97);
        chk("held_sat_cnt", s_cycle_cnt, 15);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_ignored_busy", busy, 1);
        chk("restart_ignored_init", init, 0);
        chk("restart_ignored_sel_err", sel_err, 0);
        chk("restart_ignored_cnt", cycle_cnt, 100);
        expect_done(101);
        pc = 12'd90;
        tick();
        pc = 12'd0;
        check_done(1'b0);

        // Relaunch from DONE clears done and count (checked inside launch)
        launch(2'd0, 12'd139);
        expect_done(12);
        run_cycles(12, 12'd139, 12'd90);
        check_done(1'b0);

        // Run that never matches its halt address
        launch(2'd1, 12'd90);
`ifdef PRG_WATCHDOG_EN
        expect_done(16);
        run_cycles(16, 12'd0, 12'd0);
        check_done(1'b1);
        launch(2'd2, 12'd71);
        run_cycles(5, 12'd0, 12'd0);
`else
        run_cycles(50, 12'd0, 12'd0);
        chk("nowd_busy", busy, 1);
        chk("nowd_done", done, 0);
        chk("nowd_timeout", timeout, 0);
        chk("nowd_cnt", cycle_cnt, 50);
`endif

        // Asynchronous reset mid-RUN
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_init", init, 0);
        chk("arst_cnt", cycle_cnt, 0);
        chk("arst_timeout", timeout, 0);
        tick();
        reset = 1'b1;
        tick();

        launch(2'd2, 12'd71);
        expect_done(3);
        run_cycles(3, 12'd71, 12'd90);
        check_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
